cache_miss_ctrl: RTL

CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

---
 rtl/cache_miss_ctrl_if.sv | 28 ++
 rtl/cache_miss_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl_if.sv
// Memory-side bus of the cache miss controller: one block request at a time,
// either a block writeback (we=1) or a block fetch (we=0).
interface cache_miss_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int BLK_W  = 128
);
  // Handshake: mem_req is the valid, mem_ack is the ready/complete strobe.
  // A request completes on the rising edge where mem_req && mem_ack; until
  // then mem_req, mem_we, mem_addr and mem_wdata hold steady. mem_rdata is
  // only meaningful alongside mem_ack on a read, and mem_ack with mem_req=0
  // carries no meaning.
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BLK_W-1:0]  mem_wdata;
  logic              mem_ack;
  logic [BLK_W-1:0]  mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Cache miss controller: optional victim writeback, block fetch, then a single
// fill pulse. Define DIRTY_WB_SKIP_EN to skip the writeback for clean victims.
module cache_miss_ctrl #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 20,
  parameter int BLK_W  = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_miss,
  input  logic               wr_miss,
  input  logic               dirty,
  input  logic [ADDR_W-1:0]  miss_addr,
  input  logic [TAG_W-1:0]   victim_tag,
  input  logic [BLK_W-1:0]   victim_data,
  cache_miss_ctrl_if.master  mem,
  output logic [BLK_W-1:0]   fill_data,
  output logic               fill_wr,
  output logic               fill_rd,
  output logic               stall,
  output logic [1:0]         fsm_state
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WB_REQ    = 2'd1;
  localparam logic [1:0] FETCH_REQ = 2'd2;
  localparam logic [1:0] FILL      = 2'd3;

  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(3);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] cap_addr;
  logic [TAG_W-1:0]  cap_vtag;
  logic [BLK_W-1:0]  cap_vdata;
  logic              cap_wr;
  logic              miss;
  logic              need_wb;
  logic              capture;

  assign miss    = rd_miss | wr_miss;
  assign capture = (state == IDLE) && miss;

`ifdef DIRTY_WB_SKIP_EN
  assign need_wb = dirty;
`else
  // Every victim is written back; dirty is still read so both builds share
  // one port list.
  assign need_wb = dirty | 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (miss)        state_nxt = need_wb ? WB_REQ : FETCH_REQ;
      WB_REQ:    if (mem.mem_ack) state_nxt = FETCH_REQ;
      FETCH_REQ: if (mem.mem_ack) state_nxt = FILL;
      FILL:                       state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Read wins when both misses are raised; the write is seen again later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_addr  <= '0;
      cap_vtag  <= '0;
      cap_vdata <= '0;
      cap_wr    <= 1'b0;
    end else if (capture) begin
      cap_addr  <= miss_addr & BLK_MASK;
      cap_vtag  <= victim_tag;
      cap_vdata <= victim_data;
      cap_wr    <= ~rd_miss;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_data <= '0;
    end else if ((state == FETCH_REQ) && mem.mem_ack) begin
      fill_data <= mem.mem_rdata;
    end
  end

  // Request outputs decode only registered state, so they hold until ack.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (state)
      WB_REQ: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = {cap_vtag, cap_addr[ADDR_W-TAG_W-1:0]};
        mem.mem_wdata = cap_vdata;
      end
      FETCH_REQ: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = cap_addr;
      end
      default: ;
    endcase
  end

  assign fill_rd   = (state == FILL) && !cap_wr;
  assign fill_wr   = (state == FILL) &&  cap_wr;
  assign stall     = (state != IDLE);
  assign fsm_state = state;

endmodule
